// File: rtl/core_task_timer_if.sv
// Dispatcher-side bundle for the multi-channel core task timer.
// The master drives job requests; the slave (timer) returns per-channel status pulses.
interface core_task_timer_if #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 7
);
  logic [NUM_CORES-1:0]       start;
  logic [NUM_CORES*CNT_W-1:0] run_len;
  logic [NUM_CORES-1:0]       auto_mode;
  logic [NUM_CORES-1:0]       abort;
  logic [NUM_CORES-1:0]       busy;
  logic [NUM_CORES-1:0]       done;
  logic [NUM_CORES-1:0]       start_rej;
  logic                       all_done;

  modport master (
    output start, run_len, auto_mode, abort,
    input  busy, done, start_rej, all_done
  );

  modport slave (
    input  start, run_len, auto_mode, abort,
    output busy, done, start_rej, all_done
  );
endinterface

// File: rtl/core_task_timer.sv
// NUM_CORES independent run-length timers. Each channel counts a started job down
// and pulses done on completion, optionally reloading itself for periodic jobs.
module core_task_timer #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  core_task_timer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e               state_q [NUM_CORES];
  state_e               state_d [NUM_CORES];
  logic [CNT_W-1:0]     cnt_q   [NUM_CORES];
  logic [CNT_W-1:0]     cnt_d   [NUM_CORES];
  logic [CNT_W-1:0]     len_q   [NUM_CORES];
  logic [CNT_W-1:0]     len_d   [NUM_CORES];
  logic [NUM_CORES-1:0] auto_q, auto_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic [NUM_CORES-1:0] rej_q, rej_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic                 all_done_q, all_done_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    auto_d  = auto_q;
    done_d  = '0;
    rej_d   = '0;
    busy_q  = '0;
    busy_d  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      busy_q[i] = (state_q[i] == RUN);
      case (state_q[i])
        IDLE: begin
          // Abort in IDLE swallows a coincident start.
          if (bus.start[i] && !bus.abort[i]) begin
            state_d[i] = RUN;
            cnt_d[i]   = bus.run_len[i*CNT_W +: CNT_W];
            len_d[i]   = bus.run_len[i*CNT_W +: CNT_W];
            auto_d[i]  = bus.auto_mode[i];
          end
        end
        RUN: begin
          if (bus.abort[i]) begin
            state_d[i] = IDLE;
          end else begin
            rej_d[i] = bus.start[i];
            if (cnt_q[i] == '0) begin
              done_d[i] = 1'b1;
              if (auto_q[i]) cnt_d[i]   = len_q[i];
              else           state_d[i] = IDLE;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
      busy_d[i] = (state_d[i] == RUN);
    end
    // Only a completion that empties the whole machine counts; abort-only drains do not.
    all_done_d = (|busy_q) && !(|busy_d) && (|done_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-channel arrays are plain flops, so they are reset explicitly.
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        len_q[i]   <= '0;
      end
      auto_q     <= '0;
      done_q     <= '0;
      rej_q      <= '0;
      all_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      auto_q     <= auto_d;
      done_q     <= done_d;
      rej_q      <= rej_d;
      all_done_q <= all_done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.start_rej = rej_q;
  assign bus.all_done  = all_done_q;

endmodule

// File: tb/tb_core_task_timer.sv
// Self-checking bench for core_task_timer: directed scenarios plus random traffic,
// all compared against a deadline-based reference model.
module tb_core_task_timer;
  localparam int NC = 4;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_task_timer_if #(.NUM_CORES(NC), .CNT_W(CW)) bus ();

  core_task_timer #(.NUM_CORES(NC), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: each active channel knows the absolute edge index of its next completion.
  bit m_act [NC];
  int m_deadline [NC];
  int m_len [NC];
  bit m_auto [NC];
  logic [NC-1:0] e_busy, e_done, e_rej;
  logic          e_all;

  function automatic logic [3*NC:0] obs();
    return {bus.busy, bus.done, bus.start_rej, bus.all_done};
  endfunction

  function automatic logic [3*NC:0] expv();
    return {e_busy, e_done, e_rej, e_all};
  endfunction

  task automatic step();
    logic [NC-1:0] prev;
    @(posedge clk);
    cyc++;
    prev = e_busy;
    e_done = '0;
    e_rej  = '0;
    for (int i = 0; i < NC; i++) begin
      if (reset) begin
        m_act[i] = 1'b0;
      end else if (m_act[i]) begin
        if (bus.abort[i]) begin
          m_act[i] = 1'b0;
        end else begin
          e_rej[i] = bus.start[i];
          if (cyc == m_deadline[i]) begin
            e_done[i] = 1'b1;
            if (m_auto[i]) m_deadline[i] += m_len[i] + 1;
            else           m_act[i] = 1'b0;
          end
        end
      end else if (bus.start[i] && !bus.abort[i]) begin
        m_act[i]      = 1'b1;
        m_len[i]      = int'(bus.run_len[i*CW +: CW]);
        m_auto[i]     = bus.auto_mode[i];
        m_deadline[i] = cyc + m_len[i] + 1;
      end
      e_busy[i] = m_act[i];
    end
    e_all = reset ? 1'b0 : ((|prev) && !(|e_busy) && (|e_done));
    #1;
  endtask

  task automatic clear_inputs();
    bus.start     = '0;
    bus.abort     = '0;
    bus.auto_mode = '0;
    bus.run_len   = '0;
  endtask

  task automatic set_len(input int ch, input int len);
    bus.run_len[ch*CW +: CW] = CW'(len);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    e_busy = '0;
    repeat (2) step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (obs() !== {(3*NC+1){1'b0}}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h want=0", cyc, obs());
      end
    end
  endtask

  task automatic test_one_shot();
    int t, done_at, all_at;
    done_at = -1; all_at = -1;
    set_len(0, 5);
    bus.start[0] = 1'b1;
    step();
    t = cyc;
    clear_inputs();
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL one_shot_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      if (bus.done[0]) done_at = cyc;
      if (bus.all_done) all_at = cyc;
    end
    checks++;
    if (done_at !== t + 6) begin
      errors++;
      $display("FAIL one_shot_done_time got=%0d want=%0d", done_at - t, 6);
    end
    checks++;
    if (all_at !== t + 6) begin
      errors++;
      $display("FAIL one_shot_all_done got=%0d want=%0d", all_at - t, 6);
    end
  endtask

  task automatic test_auto_repeat();
    int t, last, pulses;
    pulses = 0;
    set_len(1, 127);
    bus.auto_mode[1] = 1'b1;
    bus.start[1] = 1'b1;
    step();
    t = cyc;
    last = t;
    clear_inputs();
    for (int k = 0; k < 4 * 128; k++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL auto_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      if (bus.done[1]) begin
        pulses++;
        checks++;
        if (cyc - last !== 128) begin
          errors++;
          $display("FAIL auto_period got=%0d want=128", cyc - last);
        end
        last = cyc;
      end
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL auto_pulses got=%0d want=4", pulses);
    end
    bus.abort[1] = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (bus.busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL auto_abort_busy got=%b want=0", bus.busy[1]);
    end
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (bus.done[1]) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL auto_after_abort done_count=%0d want=0", pulses);
    end
  endtask

  task automatic test_start_rej();
    int t, done_at, rej_at;
    done_at = -1; rej_at = -1;
    set_len(2, 3);
    bus.start[2] = 1'b1;
    step();
    t = cyc;
    clear_inputs();
    step();
    set_len(2, 9);
    bus.start[2] = 1'b1;
    step();
    clear_inputs();
    if (bus.start_rej[2]) rej_at = cyc;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL rej_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
      if (bus.start_rej[2]) rej_at = cyc;
      if (bus.done[2]) done_at = cyc;
    end
    checks++;
    if (rej_at !== t + 2) begin
      errors++;
      $display("FAIL start_rej_time got=%0d want=2", rej_at - t);
    end
    checks++;
    if (done_at !== t + 4) begin
      errors++;
      $display("FAIL rej_done_time got=%0d want=4", done_at - t);
    end
  endtask

  task automatic test_simultaneous();
    int alls, both;
    alls = 0; both = 0;
    set_len(0, 4);
    set_len(3, 4);
    bus.start = 4'b1001;
    step();
    clear_inputs();
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.all_done) alls++;
      if (bus.done == 4'b1001) both++;
    end
    checks++;
    if (alls !== 1 || both !== 1) begin
      errors++;
      $display("FAIL simul_done all_done=%0d both=%0d want 1 and 1", alls, both);
    end
    set_len(0, 4);
    set_len(3, 4);
    bus.start = 4'b1001;
    step();
    clear_inputs();
    repeat (4) step();
    bus.abort[3] = 1'b1;
    step();
    clear_inputs();
    checks++;
    if ({bus.done, bus.all_done} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL abort_on_completion got=%b want=00011", {bus.done, bus.all_done});
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    set_len(0, 20);
    bus.start[0] = 1'b1;
    step();
    clear_inputs();
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (obs() !== {(3*NC+1){1'b0}}) begin
      errors++;
      $display("FAIL reset_mid_run got=%h want=0", obs());
    end
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.done[0]) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_mid_run_done count=%0d want=0", dones);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NC; i++) begin
        bus.start[i]     = ($urandom_range(0, 5) == 0);
        bus.abort[i]     = ($urandom_range(0, 40) == 0);
        bus.auto_mode[i] = ($urandom_range(0, 3) == 0);
        set_len(i, $urandom_range(0, 12));
      end
      reset = ($urandom_range(0, 400) == 0);
      step();
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs(), expv());
      end
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_repeat();
    test_start_rej();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
